// File: rtl/seven_seg_scanner.sv
// Time-multiplexed 4-digit common-anode seven-segment scanner with frame-synchronous updates.
// Optional leading-zero blanking is enabled by defining SEVSEG_LZB_EN.
module seven_seg_scanner #(
  parameter int DRIVE_CYC = 50000,
  parameter int GUARD_CYC = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] dig_one,
  input  logic [3:0] dig_ten,
  input  logic [3:0] dig_hun,
  input  logic [3:0] dig_thou,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       frame
);

  localparam int MAX_CYC = (DRIVE_CYC > GUARD_CYC) ? DRIVE_CYC : GUARD_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYC - 1);
  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(DRIVE_CYC - 1);

  typedef enum logic {GUARD, DRIVE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       idx, idx_nxt;
  logic             frame_start;
  logic [15:0]      pend, act;
  logic [15:0]      din;
  logic [3:0]       cur;
  logic             blank;
  logic [6:0]       seg_nxt;
  logic [3:0]       an_nxt;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b0111111;
    endcase
  endfunction

  assign din = {dig_thou, dig_hun, dig_ten, dig_one};

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt + 1'b1;
    idx_nxt     = idx;
    frame_start = 1'b0;
    case (state)
      GUARD: begin
        if (cnt == GUARD_LAST) begin
          state_nxt = DRIVE;
          cnt_nxt   = '0;
        end
      end
      DRIVE: begin
        if (cnt == DRIVE_LAST) begin
          state_nxt   = GUARD;
          cnt_nxt     = '0;
          idx_nxt     = idx + 2'd1;
          frame_start = (idx == 2'd3);
        end
      end
      default: state_nxt = GUARD;
    endcase
  end

  always_comb begin
    case (idx)
      2'd0:    cur = act[3:0];
      2'd1:    cur = act[7:4];
      2'd2:    cur = act[11:8];
      default: cur = act[15:12];
    endcase
  end

`ifdef SEVSEG_LZB_EN
  // A digit is blanked only when it and every more-significant digit are zero.
  always_comb begin
    case (idx)
      2'd3:    blank = (act[15:12] == 4'd0);
      2'd2:    blank = (act[15:8] == 8'd0);
      2'd1:    blank = (act[15:4] == 12'd0);
      default: blank = 1'b0;
    endcase
  end
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    seg_nxt = 7'h7F;
    an_nxt  = 4'hF;
    if (state == DRIVE) begin
      an_nxt  = ~(4'b0001 << idx);
      seg_nxt = blank ? 7'h7F : decode(cur);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= GUARD;
      cnt   <= '0;
      idx   <= 2'd0;
      pend  <= 16'd0;
      act   <= 16'd0;
      seg   <= 7'h7F;
      an    <= 4'hF;
      frame <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      if (load)
        pend <= din;
      // A load on the frame-start edge bypasses pend so the new frame shows it.
      if (frame_start)
        act <= load ? din : pend;
      seg   <= seg_nxt;
      an    <= an_nxt;
      frame <= frame_start;
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner: table vectors, corner sequences and random loads
// checked every cycle against a timeline model of the scan (honours SEVSEG_LZB_EN).
module tb_seven_seg_scanner;

  localparam int DRV = 4;
  localparam int GRD = 2;
  localparam int DIG = DRV + GRD;
  localparam int FRM = 4 * DIG;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load = 1'b0;
  logic [3:0] dig_one = 4'd0, dig_ten = 4'd0, dig_hun = 4'd0, dig_thou = 4'd0;
  logic [6:0] seg;
  logic [3:0] an;
  logic       frame;

  seven_seg_scanner #(.DRIVE_CYC(DRV), .GUARD_CYC(GRD)) dut (
    .clk(clk), .rst_n(rst_n), .load(load),
    .dig_one(dig_one), .dig_ten(dig_ten), .dig_hun(dig_hun), .dig_thou(dig_thou),
    .seg(seg), .an(an), .frame(frame)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  int          k = 0;
  logic [15:0] mpend = 16'd0;
  logic [15:0] mact = 16'd0;
  logic [6:0]  cap [4];

  logic [6:0] pat [16];
  initial begin
    pat[0] = 7'b1000000; pat[1] = 7'b1111001; pat[2] = 7'b0100100; pat[3] = 7'b0110000;
    pat[4] = 7'b0011001; pat[5] = 7'b0010010; pat[6] = 7'b0000010; pat[7] = 7'b1111000;
    pat[8] = 7'b0000000; pat[9] = 7'b0010000;
    for (int i = 10; i < 16; i++) pat[i] = 7'b0111111;
  end

  function automatic logic [6:0] ref_seg(input logic [15:0] a, input int d);
    logic [3:0] v;
    v = 4'((a >> (4 * d)) & 16'hF);
`ifdef SEVSEG_LZB_EN
    if (d > 0 && (a >> (4 * d)) == 16'd0) return 7'h7F;
`endif
    return pat[v];
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic step(input logic ld, input logic [3:0] o, t, h, th);
    int s, d, ph;
    logic [3:0] ean;
    logic [6:0] eseg;
    logic       efr;
    logic [15:0] din;
    load = ld; dig_one = o; dig_ten = t; dig_hun = h; dig_thou = th;
    din = {th, h, t, o};
    @(posedge clk);
    k++;
    s  = k - 1;
    d  = (s / DIG) % 4;
    ph = s % DIG;
    if (ph < GRD) begin
      ean = 4'hF; eseg = 7'h7F;
    end else begin
      ean = ~(4'b0001 << d); eseg = ref_seg(mact, d);
    end
    efr = (k % FRM == 0);
    if (efr) mact = ld ? din : mpend;
    if (ld) mpend = din;
    #1;
    chk("an", an, ean);
    chk("seg", seg, eseg);
    chk("frame", frame, efr);
    for (int i = 0; i < 4; i++)
      if (an == ~(4'b0001 << i)) cap[i] = seg;
    load = 1'b0;
  endtask

  task automatic idle_until(input int phase);
    for (int i = 0; i < FRM + 2 && (k % FRM) != phase; i++) step(1'b0, 0, 0, 0, 0);
    if ((k % FRM) != phase) chk("phase_timeout", k % FRM, phase);
  endtask

  typedef struct {
    logic [3:0] one, ten, hun, thou;
    logic       at_frame;
    logic [6:0] exp [4];
  } vec_t;

  vec_t tbl [5];

  initial begin
    tbl[0] = '{4'd1, 4'd2, 4'd3, 4'd4, 1'b0, '{7'h79, 7'h24, 7'h30, 7'h19}};
`ifdef SEVSEG_LZB_EN
    tbl[1] = '{4'd0, 4'd5, 4'd0, 4'd0, 1'b1, '{7'h40, 7'h12, 7'h7F, 7'h7F}};
    tbl[2] = '{4'd7, 4'hC, 4'd9, 4'd0, 1'b0, '{7'h78, 7'h3F, 7'h10, 7'h7F}};
    tbl[3] = '{4'd0, 4'd0, 4'd0, 4'd0, 1'b0, '{7'h40, 7'h7F, 7'h7F, 7'h7F}};
    tbl[4] = '{4'd8, 4'd6, 4'hF, 4'd0, 1'b1, '{7'h00, 7'h02, 7'h3F, 7'h7F}};
`else
    tbl[1] = '{4'd0, 4'd5, 4'd0, 4'd0, 1'b1, '{7'h40, 7'h12, 7'h40, 7'h40}};
    tbl[2] = '{4'd7, 4'hC, 4'd9, 4'd0, 1'b0, '{7'h78, 7'h3F, 7'h10, 7'h40}};
    tbl[3] = '{4'd0, 4'd0, 4'd0, 4'd0, 1'b0, '{7'h40, 7'h40, 7'h40, 7'h40}};
    tbl[4] = '{4'd8, 4'd6, 4'hF, 4'd0, 1'b1, '{7'h00, 7'h02, 7'h3F, 7'h40}};
`endif

    // Reset held
    repeat (3) @(posedge clk);
    #1;
    chk("rst_an", an, 4'hF);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_frame", frame, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Two full frames of zeros, including the first frame without a frame pulse
    repeat (2 * FRM) step(1'b0, 0, 0, 0, 0);

    // Table vectors
    foreach (tbl[n]) begin
      if (tbl[n].at_frame) begin
        step(1'b1, 4'd9, 4'd9, 4'd9, 4'd9);
        idle_until(FRM - 1);
        step(1'b1, tbl[n].one, tbl[n].ten, tbl[n].hun, tbl[n].thou);
      end else begin
        idle_until(10);
        step(1'b1, tbl[n].one, tbl[n].ten, tbl[n].hun, tbl[n].thou);
        idle_until(0);
      end
      for (int i = 0; i < 4; i++) cap[i] = 7'h55;
      repeat (FRM) step(1'b0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) chk($sformatf("tbl%0d_dig%0d", n, i), cap[i], tbl[n].exp[i]);
    end

    // Random loads, checked every cycle against the model
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 7) == 0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));

    // Asynchronous reset in the middle of digit 2's drive window
    for (int i = 0; i < FRM + 2 && an != 4'b1011; i++) step(1'b0, 0, 0, 0, 0);
    chk("reach_idx2", an, 4'b1011);
    step(1'b0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_an", an, 4'hF);
    chk("mid_rst_seg", seg, 7'h7F);
    chk("mid_rst_frame", frame, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    k = 0; mpend = 16'd0; mact = 16'd0;
    for (int i = 0; i < 4; i++) cap[i] = 7'h55;
    repeat (FRM) step(1'b0, 0, 0, 0, 0);
    chk("post_rst_one", cap[0], 7'b1000000);
    repeat (FRM) step(1'b0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
